// File: rtl/ads8361_pkg.sv
// ads8361_pkg
// Shared definitions for the ADS8361 device-side emulator: FSM state codes,
// the nominal conversion period in ADC clocks, and the default word width.
package ads8361_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ARMED = 2'd1;
   localparam state_t ST_LEAD  = 2'd2;
   localparam state_t ST_DATA  = 2'd3;

   // ADC clocks between conversion starts issued by the interface master
   localparam int FRAME_CLKS = 20;

   localparam int DEFAULT_DATA_BITS = 16;

endpackage

// File: rtl/ads8361_edge_sync.sv
// ads8361_edge_sync
// Brings an asynchronous level (the master's ADC clock) into the i_clk domain
// through a flop chain and reports its rising and falling transitions as
// single-cycle pulses, judged against a one-flop history of the synchronized level.
module ads8361_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic raw,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   // Synchronizer chain plus one flop of history for edge comparison
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         hist_q <= synced;
      end
   end

   assign rise = synced & ~hist_q;
   assign fall = ~synced & hist_q;

endmodule

// File: rtl/ads8361_emulator.sv
// ads8361_emulator
// Device-side model of the ADS8361 dual-channel serial ADC. The master's ADC
// clock is sampled as data; a conversion start seen on its rising edge captures
// the A/B words, and the frame (indicator bits, then the words MSB first) is
// shifted out on the two data lines, updating only on falling ADC clock edges.
module ads8361_emulator
   import ads8361_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_BITS   = DEFAULT_DATA_BITS,
   parameter int LEAD_CLKS   = 2,
   parameter bit ALTERNATE   = 1'b1
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_adc_clock,
   input  logic                 i_conv_start,
   input  logic [DATA_BITS-1:0] i_sample_a,
   input  logic [DATA_BITS-1:0] i_sample_b,
   input  logic                 i_sample_valid,
   output logic                 o_adc_data1,
   output logic                 o_adc_data2,
   output logic                 o_busy,
   output logic                 o_frame_done,
   output logic                 o_frame_error,
   output logic                 o_channel_sel
);

   localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int LEAD_W = $clog2(LEAD_CLKS + 1);

   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'(LEAD_CLKS);

   logic                   adc_rise;
   logic                   adc_fall;
   logic [SYNC_STAGES-1:0] conv_sync_q;
   logic                   conv_synced;

   logic [DATA_BITS-1:0]   hold_a;
   logic [DATA_BITS-1:0]   hold_b;
   logic [DATA_BITS-1:0]   cap_a;
   logic [DATA_BITS-1:0]   cap_b;
   logic [DATA_BITS-1:0]   shift_a;
   logic [DATA_BITS-1:0]   shift_b;

   state_t                 state;
   logic [BIT_W-1:0]       bit_cnt;
   logic [LEAD_W-1:0]      lead_cnt;
   logic                   frame_toggle;
   logic                   channel_sel;
   logic                   data1_q;
   logic                   data2_q;
   logic                   done_q;
   logic                   error_q;
   logic                   next_bit1;
   logic                   next_bit2;

   ads8361_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_clock_sync (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .raw       (i_adc_clock),
      .rise      (adc_rise),
      .fall      (adc_fall)
   );

   // Conversion start only needs the level, delayed to line up with the clock edge pulses
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         conv_sync_q <= '0;
      end else begin
         conv_sync_q <= {conv_sync_q[SYNC_STAGES-2:0], i_conv_start};
      end
   end

   assign conv_synced = conv_sync_q[SYNC_STAGES-1];

   // Holding registers follow the fabric whenever it offers a new sample pair
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         hold_a <= '0;
         hold_b <= '0;
      end else if (i_sample_valid) begin
         hold_a <= i_sample_a;
         hold_b <= i_sample_b;
      end
   end

   // A valid arriving on the capture cycle wins over the older held words
   assign cap_a = i_sample_valid ? i_sample_a : hold_a;
   assign cap_b = i_sample_valid ? i_sample_b : hold_b;

   // Line 1 carries B when the channels are swapped for this frame
   assign next_bit1 = channel_sel ? shift_b[DATA_BITS-1] : shift_a[DATA_BITS-1];
   assign next_bit2 = channel_sel ? shift_a[DATA_BITS-1] : shift_b[DATA_BITS-1];

   // Frame sequencer: captures on rising ADC edges, drives the lines on falling ones
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state        <= ST_IDLE;
         shift_a      <= '0;
         shift_b      <= '0;
         bit_cnt      <= '0;
         lead_cnt     <= '0;
         frame_toggle <= 1'b0;
         channel_sel  <= 1'b0;
         data1_q      <= 1'b0;
         data2_q      <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;

         if (adc_rise && conv_synced) begin
            if (state == ST_IDLE) begin
               shift_a <= cap_a;
               shift_b <= cap_b;
               if (ALTERNATE) begin
                  channel_sel  <= frame_toggle;
                  frame_toggle <= ~frame_toggle;
               end
               state <= ST_ARMED;
            end else begin
               error_q <= 1'b1;
            end
         end

         if (adc_fall) begin
            case (state)
               ST_ARMED: begin
                  data1_q  <= ~channel_sel;
                  data2_q  <= channel_sel;
                  lead_cnt <= LEAD_W'(1);
                  state    <= ST_LEAD;
               end
               ST_LEAD: begin
                  if (lead_cnt == LEAD_LAST) begin
                     data1_q <= next_bit1;
                     data2_q <= next_bit2;
                     shift_a <= shift_a << 1;
                     shift_b <= shift_b << 1;
                     bit_cnt <= BIT_LAST;
                     state   <= ST_DATA;
                  end else begin
                     lead_cnt <= lead_cnt + 1'b1;
                  end
               end
               ST_DATA: begin
                  if (bit_cnt == '0) begin
                     data1_q <= 1'b0;
                     data2_q <= 1'b0;
                     done_q  <= 1'b1;
                     state   <= ST_IDLE;
                  end else begin
                     data1_q <= next_bit1;
                     data2_q <= next_bit2;
                     shift_a <= shift_a << 1;
                     shift_b <= shift_b << 1;
                     bit_cnt <= bit_cnt - 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign o_adc_data1   = data1_q;
   assign o_adc_data2   = data2_q;
   assign o_busy        = (state != ST_IDLE);
   assign o_frame_done  = done_q;
   assign o_frame_error = error_q;
   assign o_channel_sel = channel_sel;

endmodule

// File: tb/tb_ads8361_emulator.sv
// tb_ads8361_emulator
// Plays the ADC interface master: drives a 10:1 ADC clock and conversion
// starts, samples both data lines on each rising ADC edge, and compares the
// captured frames with the words the fabric handed over.
module tb_ads8361_emulator;
   import ads8361_pkg::*;

   localparam int SYNC  = 2;
   localparam int DBITS = 16;
   localparam int LEAD  = 2;
   localparam bit ALT   = 1'b1;
   localparam int HALF  = SYNC + 3;
   localparam int NS    = LEAD + DBITS + 1;

   logic             i_clk;
   logic             i_reset_n;
   logic             i_adc_clock;
   logic             i_conv_start;
   logic [DBITS-1:0] i_sample_a;
   logic [DBITS-1:0] i_sample_b;
   logic             i_sample_valid;
   logic             o_adc_data1;
   logic             o_adc_data2;
   logic             o_busy;
   logic             o_frame_done;
   logic             o_frame_error;
   logic             o_channel_sel;

   int               assert_count = 0;
   int               fail_count   = 0;
   int               done_count   = 0;
   int               error_count  = 0;
   bit               monitor_on   = 1'b0;
   logic             prev_done    = 1'b0;
   int               frames_since_reset = 0;
   logic [DBITS-1:0] hold_a = '0;
   logic [DBITS-1:0] hold_b = '0;
   logic [NS-1:0]    g1;
   logic [NS-1:0]    g2;

   ads8361_emulator #(
      .SYNC_STAGES (SYNC),
      .DATA_BITS   (DBITS),
      .LEAD_CLKS   (LEAD),
      .ALTERNATE   (ALT)
   ) dut (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_adc_clock    (i_adc_clock),
      .i_conv_start   (i_conv_start),
      .i_sample_a     (i_sample_a),
      .i_sample_b     (i_sample_b),
      .i_sample_valid (i_sample_valid),
      .o_adc_data1    (o_adc_data1),
      .o_adc_data2    (o_adc_data2),
      .o_busy         (o_busy),
      .o_frame_done   (o_frame_done),
      .o_frame_error  (o_frame_error),
      .o_channel_sel  (o_channel_sel)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // What one line must show at the NS rising-edge samples after capture
   function automatic logic [NS-1:0] expectedLine(input logic [DBITS-1:0] word, input logic ind);
      logic [NS-1:0] v;
      v = '0;
      for (int i = 0; i < LEAD; i++) v[NS-1-i] = ind;
      v[DBITS:1] = word;
      v[0] = 1'b0;
      return v;
   endfunction

   // Pulse counting and pulse-shape checks on every system clock
   always @(negedge i_clk) begin
      if (monitor_on) begin
         if (o_frame_done)  done_count++;
         if (o_frame_error) error_count++;
         checkOutput("done_error_exclusive", 32'(o_frame_done & o_frame_error), 32'd0);
         checkOutput("done_single_cycle", 32'(o_frame_done & prev_done), 32'd0);
      end
      prev_done = o_frame_done;
   end

   task automatic loadWords(input logic [DBITS-1:0] a, input logic [DBITS-1:0] b);
      @(negedge i_clk);
      i_sample_a     = a;
      i_sample_b     = b;
      i_sample_valid = 1'b1;
      @(negedge i_clk);
      i_sample_valid = 1'b0;
      hold_a = a;
      hold_b = b;
   endtask

   task automatic resetDut();
      @(negedge i_clk);
      i_reset_n    = 1'b0;
      i_adc_clock  = 1'b0;
      i_conv_start = 1'b0;
      repeat (3) @(negedge i_clk);
      i_reset_n = 1'b1;
      frames_since_reset = 0;
      hold_a = '0;
      hold_b = '0;
   endtask

   // One ADC clock: low phase with conv level, then high phase; lines sampled at the rise
   task automatic applyStimulus(input logic conv, input logic bypass,
                                input logic [DBITS-1:0] bp_a, input logic [DBITS-1:0] bp_b,
                                input logic reset_mid,
                                output logic s1, output logic s2, output logic sbusy, output logic ssel);
      @(negedge i_clk);
      i_adc_clock  = 1'b0;
      i_conv_start = conv;
      repeat (HALF) @(negedge i_clk);
      i_adc_clock = 1'b1;
      s1    = o_adc_data1;
      s2    = o_adc_data2;
      sbusy = o_busy;
      ssel  = o_channel_sel;
      for (int i = 1; i < HALF; i++) begin
         @(negedge i_clk);
         if (bypass && i == SYNC) begin
            i_sample_a     = bp_a;
            i_sample_b     = bp_b;
            i_sample_valid = 1'b1;
         end
         if (bypass && i == SYNC + 1) i_sample_valid = 1'b0;
         if (reset_mid && i == 1) i_reset_n = 1'b0;
         if (reset_mid && i == 2) begin
            i_reset_n = 1'b1;
            checkOutput("abort_data1", 32'(o_adc_data1), 32'd0);
            checkOutput("abort_data2", 32'(o_adc_data2), 32'd0);
            checkOutput("abort_busy", 32'(o_busy), 32'd0);
            checkOutput("abort_sel", 32'(o_channel_sel), 32'd0);
         end
      end
   endtask

   // One 20-clock conversion period, compared against the expected frame
   task automatic runFrame(input int extra_conv_at, input int reset_at, input logic bypass,
                           input logic [DBITS-1:0] bp_a, input logic [DBITS-1:0] bp_b,
                           input int mid_load_at,
                           output logic [NS-1:0] got1, output logic [NS-1:0] got2);
      logic [DBITS-1:0] wa, wb;
      logic             sel, s1, s2, sb, ss, exp_busy;
      logic [NS-1:0]    exp1, exp2;
      int               done0, err0, exp_err;
      wa = bypass ? bp_a : hold_a;
      wb = bypass ? bp_b : hold_b;
      if (bypass) begin
         hold_a = bp_a;
         hold_b = bp_b;
      end
      sel  = ALT ? frames_since_reset[0] : 1'b0;
      exp1 = expectedLine(sel ? wb : wa, ~sel);
      exp2 = expectedLine(sel ? wa : wb, sel);
      done0 = done_count;
      err0  = error_count;
      got1 = '0;
      got2 = '0;
      applyStimulus(1'b1, bypass, bp_a, bp_b, 1'b0, s1, s2, sb, ss);
      checkOutput("busy_before_capture", 32'(sb), 32'd0);
      frames_since_reset++;
      for (int k = 1; k < FRAME_CLKS; k++) begin
         if (k == mid_load_at) loadWords(16'($urandom), 16'($urandom));
         applyStimulus(k == extra_conv_at, 1'b0, '0, '0, k == reset_at, s1, s2, sb, ss);
         got1[NS-k] = s1;
         got2[NS-k] = s2;
         if (reset_at > 0 && k > reset_at) begin
            exp_busy = 1'b0;
            exp1[NS-k] = 1'b0;
            exp2[NS-k] = 1'b0;
         end else begin
            exp_busy = (k < FRAME_CLKS - 1);
         end
         checkOutput("frame_busy", 32'(sb), 32'(exp_busy));
         if (k == 1) checkOutput("channel_sel", 32'(ss), 32'(sel));
      end
      if (reset_at > 0) begin
         frames_since_reset = 0;
         hold_a = '0;
         hold_b = '0;
      end
      exp_err = (extra_conv_at >= 1 && extra_conv_at <= FRAME_CLKS - 2 &&
                 (reset_at == 0 || extra_conv_at <= reset_at)) ? 1 : 0;
      checkOutput("line1_frame", 32'(got1), 32'(exp1));
      checkOutput("line2_frame", 32'(got2), 32'(exp2));
      checkOutput("done_pulses", 32'(done_count - done0), (reset_at > 0) ? 32'd0 : 32'd1);
      checkOutput("error_pulses", 32'(error_count - err0), 32'(exp_err));
   endtask

   initial begin
      i_reset_n      = 1'b0;
      i_adc_clock    = 1'b0;
      i_conv_start   = 1'b0;
      i_sample_a     = '0;
      i_sample_b     = '0;
      i_sample_valid = 1'b0;
      repeat (4) @(negedge i_clk);
      checkOutput("reset_data1", 32'(o_adc_data1), 32'd0);
      checkOutput("reset_data2", 32'(o_adc_data2), 32'd0);
      checkOutput("reset_busy", 32'(o_busy), 32'd0);
      checkOutput("reset_done", 32'(o_frame_done), 32'd0);
      checkOutput("reset_error", 32'(o_frame_error), 32'd0);
      checkOutput("reset_sel", 32'(o_channel_sel), 32'd0);
      i_reset_n  = 1'b1;
      monitor_on = 1'b1;

      $display("[TB] basic frame A=0xA5C3 B=0x0F0F");
      loadWords(16'hA5C3, 16'h0F0F);
      runFrame(0, 0, 1'b0, '0, '0, 0, g1, g2);
      checkOutput("t1_data1_literal", 32'(g1), 32'({2'b11, 16'hA5C3, 1'b0}));
      checkOutput("t1_data2_literal", 32'(g2), 32'({2'b00, 16'h0F0F, 1'b0}));

      $display("[TB] alternating channels");
      resetDut();
      loadWords(16'h8001, 16'h7FFE);
      runFrame(0, 0, 1'b0, '0, '0, 0, g1, g2);
      checkOutput("t2_f1_data1_literal", 32'(g1), 32'({2'b11, 16'h8001, 1'b0}));
      runFrame(0, 0, 1'b0, '0, '0, 0, g1, g2);
      checkOutput("t2_f2_data1_literal", 32'(g1), 32'({2'b00, 16'h7FFE, 1'b0}));
      checkOutput("t2_f2_data2_literal", 32'(g2), 32'({2'b11, 16'h8001, 1'b0}));

      $display("[TB] conversion start while busy");
      loadWords(16'($urandom), 16'($urandom));
      runFrame(LEAD + 1 + 5, 0, 1'b0, '0, '0, 0, g1, g2);

      $display("[TB] reset during data bit 8");
      loadWords(16'($urandom), 16'($urandom));
      runFrame(0, LEAD + 1 + 8, 1'b0, '0, '0, 0, g1, g2);
      loadWords(16'($urandom), 16'($urandom));
      runFrame(0, 0, 1'b0, '0, '0, 0, g1, g2);

      $display("[TB] sample valid on the capture cycle");
      resetDut();
      loadWords(16'hFFFF, 16'hFFFF);
      runFrame(0, 0, 1'b1, 16'h1234, 16'h5678, 0, g1, g2);
      checkOutput("t5_data1_literal", 32'(g1), 32'({2'b11, 16'h1234, 1'b0}));
      checkOutput("t5_data2_literal", 32'(g2), 32'({2'b00, 16'h5678, 1'b0}));

      $display("[TB] 100 random frames");
      for (int i = 0; i < 100; i++) begin
         int extra, mid;
         if (i == 0 || $urandom_range(0, 1) == 1) loadWords(16'($urandom), 16'($urandom));
         extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FRAME_CLKS - 2)) : 0;
         mid   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, FRAME_CLKS - 2)) : 0;
         runFrame(extra, 0, 1'b0, '0, '0, mid, g1, g2);
      end

      monitor_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
